pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//  Parametrised chain of DEPTH pipeline registers, each carrying a WIDTH-bit payload
//  (PC + instruction word, etc.) and a valid bit. It generalises the per-stage freeze/flush
//  stage registers of the five-stage ARM core into one block with:
//  - valid/ready flow control;
//  - bubble collapsing (an empty stage fills even while later stages are stalled);
//  - per-stage flush masks.
//  It sits between the fetch front-end and the back-end stages, and is reused for any N-stage span.
// PARAMETERS
//  WIDTH  32  payload width per stage (bits)
//  DEPTH  4   number of register stages, >=1
//  CNTW   16  width of occupancy/statistics counters
// PORTS
//  clk         in   1            rising-edge clock
//  rst         in   1            asynchronous reset, active-low
//  freeze      in   1            global hold: no stage loads or drains
//  flush       in   DEPTH        flush[i]=1 kills stage i contents this cycle
//  in_valid    in   1            upstream offers in_data
//  in_data     in   WIDTH        payload into stage 0
//  in_ready    out  1            stage 0 can accept this cycle
//  out_valid   out  1            stage DEPTH-1 holds valid data
//  out_data    out  WIDTH        payload of stage DEPTH-1
//  out_ready   in   1            downstream consumes when out_valid&&out_ready
//  stage_valid out  DEPTH        valid bit of every stage (debug/hazard taps)
//  stage_data  out  DEPTH*WIDTH  flattened payloads; stage i at [i*WIDTH +: WIDTH]
//  occupancy   out  CNTW         number of valid stages
//  stall_cnt   out  CNTW         see CONFIGURATION
//  kill_cnt    out  CNTW         see CONFIGURATION
// BEHAVIOUR
//  - Reset (rst=0, async): all valid bits 0; all payloads 0; occupancy 0; counters 0.
//    in_ready=0 while rst=0. Reset mid-transfer discards all contents; nothing is replayed.
//  - Advance terms:
//    - adv[DEPTH-1] = out_valid && out_ready && !freeze.
//    - adv[i] = valid[i] && (!valid[i+1] || adv[i+1]) && !freeze.
//    - Stage i loads (from stage i-1, or from in_data for i=0) when !freeze and
//      (!valid[i] || adv[i]).
//  - in_ready = !freeze && (!valid[0] || adv[0]). The ready chain is combinational from out_ready.
//  - out_valid = valid[DEPTH-1] && !freeze. out_data is the stage register itself (no mux).
//  - Load: valid[i] <= valid[i-1] && adv[i-1] (stage 0: in_valid && in_ready).
//    Payload loads only when the incoming valid is 1. A stage left empty keeps its stale
//    payload and has valid=0.
//  - Latency: empty chain, no stalls -> data accepted at edge t appears on out_data after edge t+DEPTH-1.
//    Throughput is 1 item/cycle.
//  - Bubble collapse: if out_ready=0, upstream items advance until every stage is full.
//    in_ready drops only when all DEPTH stages are valid.
//  - Flush: flush[i] forces valid[i] <= 0 at the edge.
//    - Any item moving into stage i on that edge is also discarded.
//    - An item leaving stage i on the same edge is not affected: it lands in i+1 unless
//      flush[i+1] is also set.
//    - Flush has priority over freeze. A flush of the output stage while out_valid&&out_ready
//      still counts as consumed, because the handshake happened this cycle.
//  - Freeze: all registers hold; in_ready=0; out_valid=0; flush still applies.
//  - occupancy = popcount(stage_valid) after each edge, registered. Maximum is DEPTH.
// CONFIGURATION
//  - Macro PIPE_REG_STATS_EN.
//  - Defined:
//    - stall_cnt increments when in_valid && !in_ready && rst.
//    - kill_cnt increments by the number of valid items destroyed by flush on each edge,
//      including items entering a flushed stage.
//    - Both counters saturate at 2^CNTW-1 and clear on reset only.
//  - Undefined: stall_cnt and kill_cnt are tied to 0, and no counter logic is synthesised.
//    The port list is unchanged.
// TESTING
//  1. Stream: WIDTH=32, DEPTH=4. in_data 0x100,0x104,... every cycle, out_ready=1.
//     -> first out_valid with 0x100 after the 4th edge; then one item per cycle in order;
//     in_ready stays 1.
//  2. Backpressure: out_ready=0 with a continuous stream.
//     -> in_ready falls after exactly 4 accepts; occupancy=4.
//     Raise out_ready -> 0x100..0x10C drain in order; no loss or duplication.
//  3. Bubble collapse: stages valid {1,0,1,0} (stage 0..3), out_ready=0, in_valid=0.
//     -> after one edge stage_valid={0,1,0,1}; after the next edge stage_valid={0,0,1,1};
//     then it holds.
//  4. Flush: full chain, flush=4'b0011 while out_ready=1 and in_valid=1.
//     -> stages 0,1 empty next cycle; stage 2 gets the item from stage 1? No: it was flushed
//        in transit only if it landed in a flushed stage; the item from 1 lands in 2.
//     -> kill_cnt +2 (stage 0 and the new input item); occupancy=2.
//  5. Freeze with flush: freeze=1 for 3 cycles.
//     -> payloads unchanged; in_ready=0; out_valid=0.
//     Assert flush[3] during the freeze -> stage 3 cleared regardless.
//  6. Async reset mid-stream: drop rst between edges.
//     -> stage_valid=0, out_valid=0, counters=0 immediately.
//     Release -> first new accept comes out after DEPTH edges.
//     With PIPE_REG_STATS_EN undefined, stall_cnt and kill_cnt read 0 throughout.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain with bubble collapse, flush and freeze.
// Define PIPE_REG_STATS_EN to build the stall_cnt / kill_cnt statistics counters.
module pipe_reg_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic [DEPTH-1:0]       flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [CNTW-1:0]        occupancy,
  output logic [CNTW-1:0]        stall_cnt,
  output logic [CNTW-1:0]        kill_cnt
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] vin;
  logic [DEPTH-1:0] v_hold;
  logic [DEPTH-1:0] v_nxt;
  logic [WIDTH-1:0] dat [DEPTH];

  // Closed form of the advance recursion: a stage moves when any
  // later stage is empty or the output is consumed.
  always_comb begin
    adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic room;
      room = out_ready;
      for (int j = i + 1; j < DEPTH; j++) begin
        room = room || !vld[j];
      end
      adv[i] = !freeze && vld[i] && room;
    end
  end

  always_comb begin
    load   = '0;
    vin    = '0;
    v_hold = '0;
    for (int i = 0; i < DEPTH; i++) begin
      load[i] = !freeze && (!vld[i] || adv[i]);
    end
    vin[0] = in_valid && in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      vin[i] = adv[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      v_hold[i] = load[i] ? vin[i] : vld[i];
    end
  end

  assign v_nxt     = v_hold & ~flush;
  assign in_ready  = rst && load[0];
  assign out_valid = vld[DEPTH-1] && !freeze;
  assign out_data  = dat[DEPTH-1];
  assign stage_valid = vld;

  for (genvar g = 0; g < DEPTH; g++) begin : g_tap
    assign stage_data[g*WIDTH +: WIDTH] = dat[g];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld       <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld       <= v_nxt;
      occupancy <= CNTW'($countones(v_nxt));
      if (load[0] && vin[0]) begin
        dat[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i] && vin[i]) begin
          dat[i] <= dat[i-1];
        end
      end
    end
  end

`ifdef PIPE_REG_STATS_EN
  logic [CNTW:0] kinc;
  logic [CNTW:0] ksum;
  logic          stall_ev;

  // Items that would have been held or received but are flushed.
  assign kinc     = (CNTW+1)'($countones(flush & v_hold));
  assign ksum     = {1'b0, kill_cnt} + kinc;
  assign stall_ev = in_valid && !in_ready && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (stall_ev && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      kill_cnt <= ksum[CNTW] ? '1 : ksum[CNTW-1:0];
    end
  end
`else
  assign stall_cnt = '0;
  assign kill_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: scoreboard on the output handshake
// plus explicit state checks for collapse, flush, freeze and reset.
module tb_pipe_reg_chain;

  localparam int W = 32;
  localparam int D = 4;
  localparam int C = 16;
`ifdef PIPE_REG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           freeze;
  logic [D-1:0]   flush;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [D-1:0]   stage_valid;
  logic [D*W-1:0] stage_data;
  logic [C-1:0]   occupancy;
  logic [C-1:0]   stall_cnt;
  logic [C-1:0]   kill_cnt;

  int total = 0;
  int bad = 0;
  logic [W-1:0] sb [$];
  logic last_rdy;
  logic last_acc;
  int n;

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .CNTW(C)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then update the scoreboard.
  task automatic cyc();
    logic acc, con;
    logic [W-1:0] di, dq;
    @(negedge clk);
    acc = in_valid && in_ready;
    con = out_valid && out_ready;
    last_rdy = in_ready;
    last_acc = acc;
    di = in_data;
    dq = out_data;
    @(posedge clk);
    #1;
    if (con) begin
      chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) chk("sb_data", 128'(dq), 128'(sb.pop_front()));
    end
    if (acc) sb.push_back(di);
  endtask

  task automatic cnt_chk(input string tag, input int st, input int kl);
    chk({tag, "_stall"}, 128'(stall_cnt), STATS ? 128'(st) : 128'(0));
    chk({tag, "_kill"}, 128'(kill_cnt), STATS ? 128'(kl) : 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; freeze = 1'b0; flush = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_svalid", 128'(stage_valid), 128'(0));
    chk("rst_sdata", 128'(stage_data), 128'(0));
    chk("rst_ovalid", 128'(out_valid), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(0));
    chk("rst_occ", 128'(occupancy), 128'(0));
    cnt_chk("rst", 0, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Stream
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_data = 32'(32'h100 + 4 * k);
      cyc();
      chk("t1_ready", 128'(last_rdy), 128'(1));
      chk("t1_ovalid", 128'(out_valid), 128'(k >= 3));
      if (k == 3) chk("t1_first", 128'(out_data), 128'(32'h100));
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("t1_sb_empty", 128'(sb.size()), 128'(0));
    chk("t1_occ", 128'(occupancy), 128'(0));

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      in_data = 32'(32'h100 + 4 * n);
      cyc();
      if (last_acc) n++;
      chk("t2_ready", 128'(last_rdy), 128'(k < 4));
    end
    chk("t2_accepts", 128'(n), 128'(4));
    chk("t2_occ", 128'(occupancy), 128'(4));
    chk("t2_svalid", 128'(stage_valid), 128'(4'hF));
    cnt_chk("t2", 4, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    chk("t2_sb_empty", 128'(sb.size()), 128'(0));
    repeat (2) cyc();
    chk("t2_nodup", 128'(out_valid), 128'(0));

    // Bubble collapse
    in_valid = 1'b1; in_data = 32'hA0;
    cyc();
    in_valid = 1'b0;
    cyc();
    in_valid = 1'b1; in_data = 32'hB0;
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("t3_s0", 128'(stage_valid), 128'(4'b0101));
    cyc();
    chk("t3_s1", 128'(stage_valid), 128'(4'b1010));
    cyc();
    chk("t3_s2", 128'(stage_valid), 128'(4'b1100));
    cyc();
    chk("t3_hold", 128'(stage_valid), 128'(4'b1100));
    chk("t3_data", 128'(stage_data[127:64]), 128'({32'hA0, 32'hB0}));
    out_ready = 1'b1;
    repeat (2) cyc();
    chk("t3_sb_empty", 128'(sb.size()), 128'(0));

    // Flush of stages 0,1 while streaming
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'(32'hC0 + k);
      cyc();
    end
    chk("t4_full", 128'(stage_valid), 128'(4'hF));
    flush = 4'b0011;
    out_ready = 1'b1;
    in_data = 32'hC4;
    cyc();
    flush = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("t4_sb_size", 128'(sb.size()), 128'(4));
    void'(sb.pop_back());
    void'(sb.pop_back());
    chk("t4_svalid", 128'(stage_valid), 128'(4'b1100));
    chk("t4_occ", 128'(occupancy), 128'(2));
    chk("t4_data", 128'(stage_data[127:64]), 128'({32'hC1, 32'hC2}));
    cnt_chk("t4", 4, 2);
    out_ready = 1'b1;
    repeat (2) cyc();
    chk("t4_sb_empty", 128'(sb.size()), 128'(0));

    // Freeze, with a flush of the output stage in the middle
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'(32'hD0 + k);
      cyc();
    end
    freeze = 1'b1;
    in_data = 32'hEE;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      flush = (k == 1) ? 4'b1000 : 4'b0000;
      cyc();
      flush = '0;
      chk("t5_ready", 128'(in_ready), 128'(0));
      chk("t5_ovalid", 128'(out_valid), 128'(0));
      chk("t5_data", 128'(stage_data),
          {32'hD0, 32'hD1, 32'hD2, 32'hD3});
      chk("t5_svalid", 128'(stage_valid), (k == 0) ? 128'(4'hF) : 128'(4'h7));
    end
    cnt_chk("t5", 7, 3);
    void'(sb.pop_front());
    freeze = 1'b0;
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("t5_sb_empty", 128'(sb.size()), 128'(0));

    // Asynchronous reset mid-stream
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = 32'(32'hF0 + k);
      cyc();
    end
    #2 rst = 1'b0;
    #1;
    chk("t6_svalid", 128'(stage_valid), 128'(0));
    chk("t6_ovalid", 128'(out_valid), 128'(0));
    chk("t6_ready", 128'(in_ready), 128'(0));
    chk("t6_occ", 128'(occupancy), 128'(0));
    cnt_chk("t6", 0, 0);
    sb.delete();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 32'(32'h200 + k);
      cyc();
      chk("t6_ovalid_n", 128'(out_valid), 128'(k >= 3));
      if (k == 3) chk("t6_first", 128'(out_data), 128'(32'h200));
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("t6_sb_empty", 128'(sb.size()), 128'(0));
    cnt_chk("t6_end", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
